cpu_sequencer: RTL and testbench

//  Multi-cycle fetch/execute controller for the tiny16 16x16 register file (R0 reads 0 by convention).
//  It fetches one 16-bit instruction per pass over a req/ack memory port and decodes it.
//  It drives the register file's src/dst selects, its write strobes and its PC/SP inc/dec strobes.
//  It muxes the register-file write data from four sources: memory, ALU, source register and immediate.

---
 rtl/tiny16_pkg.sv | 45 ++++
 rtl/cpu_sequencer_decode.sv | 33 +++
 rtl/cpu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny16_pkg.sv
// Shared encodings for the tiny16 fetch/execute sequencer: opcodes, FSM states,
// register indices and the decoded-instruction record.
package tiny16_pkg;

    localparam logic [3:0] DEF_PC_IDX = 4'd1;
    localparam logic [3:0] DEF_SP_IDX = 4'd2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_MOV  = 4'h1, OP_LDL  = 4'h2, OP_LDH  = 4'h3,
        OP_LD   = 4'h4, OP_ST   = 4'h5, OP_PUSH = 4'h6, OP_POP  = 4'h7,
        OP_ADD  = 4'h8, OP_SUB  = 4'h9, OP_AND  = 4'hA, OP_OR   = 4'hB,
        OP_JMP  = 4'hC, OP_JZ   = 4'hD, OP_HALT = 4'hE, OP_ILL  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH, ST_EXEC, ST_MEM, ST_SPADJ, ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_OR = 2'd3
    } alu_op_e;

    // Instruction class decides the path through the FSM after EXEC.
    typedef enum logic [2:0] {
        CLS_NOP, CLS_WRITE, CLS_MEM, CLS_POP, CLS_STOP
    } class_e;

    typedef enum logic [1:0] {
        WR_NONE, WR_FULL, WR_UPPER, WR_LOWER
    } wr_kind_e;

    typedef enum logic [1:0] {
        SRC_MEM, SRC_ALU, SRC_REG, SRC_IMM
    } reg_in_src_e;

    typedef struct packed {
        class_e      cls;
        wr_kind_e    wr;
        reg_in_src_e src;
        logic        jump;
        logic        cond;
        logic        sets_z;
    } decode_t;

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational opcode decoder: maps the opcode field to instruction class,
// register write kind and register-file write-data source.
module seq_decode
    import tiny16_pkg::*;
(
    input  logic [3:0] op,
    output decode_t    dec
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        dec = '{cls: CLS_NOP, wr: WR_NONE, src: SRC_REG, jump: 1'b0, cond: 1'b0, sets_z: 1'b0};
        case (opcode_e'(op))
            OP_NOP:  ;
            OP_MOV:  dec = '{cls: CLS_WRITE, wr: WR_FULL,  src: SRC_REG, jump: 1'b0, cond: 1'b0, sets_z: 1'b0};
            OP_LDL:  dec = '{cls: CLS_WRITE, wr: WR_LOWER, src: SRC_IMM, jump: 1'b0, cond: 1'b0, sets_z: 1'b0};
            OP_LDH:  dec = '{cls: CLS_WRITE, wr: WR_UPPER, src: SRC_IMM, jump: 1'b0, cond: 1'b0, sets_z: 1'b0};
            OP_LD:   dec = '{cls: CLS_MEM,   wr: WR_FULL,  src: SRC_MEM, jump: 1'b0, cond: 1'b0, sets_z: 1'b0};
            OP_ST,
            OP_PUSH: dec = '{cls: CLS_MEM,   wr: WR_NONE,  src: SRC_REG, jump: 1'b0, cond: 1'b0, sets_z: 1'b0};
            OP_POP:  dec = '{cls: CLS_POP,   wr: WR_FULL,  src: SRC_MEM, jump: 1'b0, cond: 1'b0, sets_z: 1'b0};
            OP_ADD,
            OP_SUB,
            OP_AND,
            OP_OR:   dec = '{cls: CLS_WRITE, wr: WR_FULL,  src: SRC_ALU, jump: 1'b0, cond: 1'b0, sets_z: 1'b1};
            OP_JMP:  dec = '{cls: CLS_WRITE, wr: WR_FULL,  src: SRC_REG, jump: 1'b1, cond: 1'b0, sets_z: 1'b0};
            OP_JZ:   dec = '{cls: CLS_WRITE, wr: WR_FULL,  src: SRC_REG, jump: 1'b1, cond: 1'b1, sets_z: 1'b0};
            OP_HALT,
            OP_ILL:  dec = '{cls: CLS_STOP,  wr: WR_NONE,  src: SRC_REG, jump: 1'b0, cond: 1'b0, sets_z: 1'b0};
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute controller for the tiny16 register file: fetches over
// a req/ack memory port, then drives register selects, write strobes and PC/SP strobes.
module cpu_sequencer
    import tiny16_pkg::*;
#(
    parameter logic [3:0] PC_IDX = DEF_PC_IDX,
    parameter logic [3:0] SP_IDX = DEF_SP_IDX
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  src_sel,
    output logic [3:0]  dst_sel,
    output logic        in_en,
    output logic        up_en,
    output logic        lo_en,
    output logic        pc_inc,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic [15:0] reg_in,
    input  logic [15:0] reg_src,
    input  logic [15:0] reg_dst,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        halted,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        z_q, z_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;

    opcode_e     op;
    logic [3:0]  fld_d, fld_s;
    logic [7:0]  imm8;
    decode_t     dec;

    assign op    = opcode_e'(ir_q[15:12]);
    assign fld_d = ir_q[11:8];
    assign fld_s = ir_q[7:4];
    assign imm8  = ir_q[7:0];

    seq_decode u_decode (
        .op  (ir_q[15:12]),
        .dec (dec)
    );

    assign alu_op  = ir_q[13:12];
    assign halted  = halted_q;
    assign illegal = illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            z_q       <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q   <= state_d;
            ir_q      <= ir_d;
            z_q       <= z_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        z_d       = z_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        src_sel   = fld_s;
        dst_sel   = fld_d;
        in_en     = 1'b0;
        up_en     = 1'b0;
        lo_en     = 1'b0;
        pc_inc    = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        reg_in    = '0;

        case (state_q)
            ST_FETCH: begin
                src_sel  = PC_IDX;
                mem_req  = 1'b1;
                mem_addr = reg_src;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_inc  = 1'b1;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (dec.src)
                    SRC_MEM: reg_in = mem_rdata;
                    SRC_ALU: reg_in = alu_result;
                    SRC_REG: reg_in = reg_src;
                    SRC_IMM: reg_in = {8'h00, imm8};
                endcase
                case (dec.cls)
                    CLS_WRITE: begin
                        if (dec.jump) dst_sel = PC_IDX;
                        // A not-taken JZ simply falls through to the next fetch.
                        if (!dec.cond || z_q) begin
                            in_en = (dec.wr == WR_FULL);
                            up_en = (dec.wr == WR_UPPER);
                            lo_en = (dec.wr == WR_LOWER);
                        end
                        if (dec.sets_z) z_d = alu_zero;
                        state_d = ST_FETCH;
                    end
                    CLS_MEM:  state_d = ST_MEM;
                    CLS_POP:  state_d = ST_SPADJ;
                    CLS_STOP: begin
                        halted_d  = 1'b1;
                        illegal_d = (op == OP_ILL);
                        state_d   = ST_HALT;
                    end
                    default:  state_d = ST_FETCH;
                endcase
            end

            ST_SPADJ: begin
                sp_inc  = 1'b1;
                state_d = ST_MEM;
            end

            ST_MEM: begin
                mem_req = 1'b1;
                reg_in  = mem_rdata;
                case (op)
                    OP_POP: begin
                        src_sel  = SP_IDX;
                        mem_addr = reg_src;
                    end
                    OP_ST: begin
                        mem_we    = 1'b1;
                        mem_addr  = reg_dst;
                        mem_wdata = reg_src;
                    end
                    OP_PUSH: begin
                        dst_sel   = SP_IDX;
                        mem_we    = 1'b1;
                        mem_addr  = reg_dst;
                        mem_wdata = reg_src;
                    end
                    default: mem_addr = reg_src;
                endcase
                if (mem_ack) begin
                    in_en   = (dec.wr == WR_FULL);
                    sp_dec  = (op == OP_PUSH);
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: ;

            default: state_d = ST_FETCH;
        endcase

        // Reset kills any in-flight access and register update immediately.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            in_en   = 1'b0;
            up_en   = 1'b0;
            lo_en   = 1'b0;
            pc_inc  = 1'b0;
            sp_inc  = 1'b0;
            sp_dec  = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: register file, memory and ALU environment around
// cpu_sequencer, an instruction-level model predicting every cycle, and directed programs.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  src_sel, dst_sel;
    logic        in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec;
    logic [15:0] reg_in, reg_src, reg_dst, alu_result;
    logic [1:0]  alu_op;
    logic        alu_zero, halted, illegal;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .src_sel(src_sel), .dst_sel(dst_sel),
        .in_en(in_en), .up_en(up_en), .lo_en(lo_en),
        .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .reg_in(reg_in), .reg_src(reg_src), .reg_dst(reg_dst),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .halted(halted), .illegal(illegal)
    );

    // ---------------- environment ----------------
    logic [15:0] rom     [0:65535];
    logic [15:0] mem     [0:65535];
    logic [15:0] rf_init [0:15];
    logic [15:0] rf      [0:15];
    int          mem_wait  = 0;
    logic        ack_force = 1'b0;
    int          wait_cnt;

    assign mem_ack   = ack_force | (mem_req && (wait_cnt == mem_wait));
    assign mem_rdata = mem[mem_addr];
    assign reg_src   = (src_sel == 4'd0) ? 16'h0000 : rf[src_sel];
    assign reg_dst   = (dst_sel == 4'd0) ? 16'h0000 : rf[dst_sel];
    assign alu_zero  = (alu_result == 16'h0000);

    always_comb begin
        case (alu_op)
            2'd0: alu_result = reg_dst + reg_src;
            2'd1: alu_result = reg_dst - reg_src;
            2'd2: alu_result = reg_dst & reg_src;
            default: alu_result = reg_dst | reg_src;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) mem[i] <= rom[i];
        end else if (mem_req && mem_we && mem_ack) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
        end else begin
            if (in_en) rf[dst_sel] <= reg_in;
            if (up_en) rf[dst_sel][15:8] <= reg_in[7:0];
            if (lo_en) rf[dst_sel][7:0] <= reg_in[7:0];
            if (pc_inc) rf[1] <= rf[1] + 16'd1;
            if (sp_inc) rf[2] <= rf[2] + 16'd1;
            if (sp_dec) rf[2] <= rf[2] - 16'd1;
        end
    end

    logic [15:0] last_fetch;
    int          req300_cnt, inen8_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            last_fetch <= 16'h0000;
            req300_cnt <= 0;
            inen8_cnt  <= 0;
        end else begin
            if (mem_req && !mem_we && mem_ack && pc_inc) last_fetch <= mem_addr;
            if (mem_req && mem_addr == 16'h0300) req300_cnt <= req300_cnt + 1;
            if (in_en && dst_sel == 4'd8) inen8_cnt <= inen8_cnt + 1;
        end
    end

    // ---------------- instruction-level model ----------------
    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  wr;      // {full, upper, lower}
        logic [3:0]  dst;
        logic [15:0] din;
        logic        pc_inc;
        logic        sp_inc;
        logic        sp_dec;
        logic        halted;
        logic        illegal;
    } cyc_t;

    cyc_t        q[$];
    logic [15:0] mr   [0:15];
    logic [15:0] mmem [0:65535];
    logic        m_z, m_halted, m_ill;
    logic        check_en = 1'b0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic cyc_t blank();
        cyc_t c;
        c = '0;
        return c;
    endfunction

    function automatic logic [15:0] rd(input logic [3:0] r);
        return (r == 4'd0) ? 16'h0000 : mr[r];
    endfunction

    function automatic logic [15:0] alu_model(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
        case (k)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic string fmt(input cyc_t c);
        return $sformatf("req=%b we=%b addr=%h wd=%h wr=%b dst=%0d din=%h pc+=%b sp+=%b sp-=%b hlt=%b ill=%b",
                         c.req, c.we, c.addr, c.wdata, c.wr, c.dst, c.din,
                         c.pc_inc, c.sp_inc, c.sp_dec, c.halted, c.illegal);
    endfunction

    function automatic cyc_t observe();
        cyc_t c;
        c = '0;
        c.req = mem_req;
        if (mem_req) begin
            c.we   = mem_we;
            c.addr = mem_addr;
            if (mem_we) c.wdata = mem_wdata;
        end
        c.wr = {in_en, up_en, lo_en};
        if (c.wr != 3'b000) begin
            c.dst = dst_sel;
            c.din = reg_in;
        end
        c.pc_inc  = pc_inc;
        c.sp_inc  = sp_inc;
        c.sp_dec  = sp_dec;
        c.halted  = halted;
        c.illegal = illegal;
        return c;
    endfunction

    task automatic push_access(input logic [15:0] a, input logic we, input logic [15:0] wd,
                               input int w, input cyc_t ack_extra);
        cyc_t c;
        c = blank();
        c.req = 1'b1; c.we = we; c.addr = a; c.wdata = wd;
        repeat (w) q.push_back(c);
        c.wr = ack_extra.wr; c.dst = ack_extra.dst; c.din = ack_extra.din;
        c.pc_inc = ack_extra.pc_inc; c.sp_dec = ack_extra.sp_dec;
        q.push_back(c);
    endtask

    // Expands the next instruction into its expected cycle sequence and updates the model state.
    task automatic model_step();
        cyc_t        c, x;
        logic [15:0] p, ir, a, v;
        logic [3:0]  op, d, s;
        logic [7:0]  imm;
        int          w;
        w = ack_force ? 0 : mem_wait;
        if (m_halted) begin
            c = blank(); c.halted = 1'b1; c.illegal = m_ill;
            q.push_back(c);
            return;
        end
        p = mr[1];
        x = blank(); x.pc_inc = 1'b1;
        push_access(p, 1'b0, 16'h0000, w, x);
        mr[1] = p + 16'd1;
        ir = mmem[p]; op = ir[15:12]; d = ir[11:8]; s = ir[7:4]; imm = ir[7:0];
        c = blank();
        case (op)
            4'h1: begin c.wr = 3'b100; c.dst = d; c.din = rd(s); mr[d] = c.din; end
            4'h2: begin c.wr = 3'b001; c.dst = d; c.din = {8'h00, imm}; mr[d][7:0] = imm; end
            4'h3: begin c.wr = 3'b010; c.dst = d; c.din = {8'h00, imm}; mr[d][15:8] = imm; end
            4'h8, 4'h9, 4'hA, 4'hB: begin
                v = alu_model(op[1:0], rd(d), rd(s));
                c.wr = 3'b100; c.dst = d; c.din = v; m_z = (v == 16'h0000); mr[d] = v;
            end
            4'hC: begin c.wr = 3'b100; c.dst = 4'd1; c.din = rd(s); mr[1] = c.din; end
            4'hD: if (m_z) begin c.wr = 3'b100; c.dst = 4'd1; c.din = rd(s); mr[1] = c.din; end
            4'hE, 4'hF: begin m_halted = 1'b1; m_ill = (op == 4'hF); end
            default: ;
        endcase
        q.push_back(c);
        case (op)
            4'h4: begin
                a = rd(s);
                x = blank(); x.wr = 3'b100; x.dst = d; x.din = mmem[a];
                push_access(a, 1'b0, 16'h0000, w, x);
                mr[d] = mmem[a];
            end
            4'h5: begin
                a = rd(d); v = rd(s);
                push_access(a, 1'b1, v, w, blank());
                mmem[a] = v;
            end
            4'h6: begin
                a = mr[2]; v = rd(s);
                x = blank(); x.sp_dec = 1'b1;
                push_access(a, 1'b1, v, w, x);
                mmem[a] = v; mr[2] = a - 16'd1;
            end
            4'h7: begin
                c = blank(); c.sp_inc = 1'b1; q.push_back(c);
                mr[2] = mr[2] + 16'd1; a = mr[2];
                x = blank(); x.wr = 3'b100; x.dst = d; x.din = mmem[a];
                push_access(a, 1'b0, 16'h0000, w, x);
                mr[d] = mmem[a];
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = rf_init[i];
        m_z = 1'b0; m_halted = 1'b0; m_ill = 1'b0;
        q.delete();
    endtask

    always @(negedge clk) begin
        cyc_t e, g;
        #1;
        if (check_en) begin
            if (q.size() == 0) model_step();
            e = q.pop_front();
            g = observe();
            n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL cycle t=%0t got {%s} expected {%s}", $time, fmt(g), fmt(e));
            end
        end
    end

    // ---------------- directed tests ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 65536; i++) begin rom[i] = 16'h0000; mmem[i] = 16'h0000; end
        for (int i = 0; i < 16; i++) rf_init[i] = 16'h0000;
        rf_init[1] = 16'h00FF;
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] v);
        rom[a] = v; mmem[a] = v;
    endtask

    task automatic start_test(input int w, input logic force_ack);
        check_en = 1'b0; rst = 1'b1; mem_wait = w; ack_force = force_ack;
        @(negedge clk); @(negedge clk);
        model_reset();
        rst = 1'b0; check_en = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin @(negedge clk); #2; n++; end
        check({name, "_halt_reached"}, {31'd0, halted}, 32'd1);
        repeat (3) begin @(negedge clk); #2; end
        check_en = 1'b0;
    endtask

    initial begin
        int cnt;

        // T1: PC=00FF, always-ack memory, LDL R1 (PC) low byte.
        clear_all();
        put(16'h00FF, 16'h2134);
        put(16'h0134, 16'hE000);
        start_test(0, 1'b1);
        #2 check("t1_fetch", {14'd0, mem_req, mem_we, mem_addr}, {14'd0, 1'b1, 1'b0, 16'h00FF});
        @(negedge clk); #2;
        check("t1_ldl_pc", {8'd0, lo_en, up_en, in_en, pc_inc, dst_sel, reg_in},
              {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0034});
        wait_halt("t1", 50);
        check("t1_next_fetch", {16'd0, last_fetch}, 32'h0134);

        // T2: SUB sets Z, JZ taken to R6.
        clear_all();
        rf_init[6] = 16'h0200;
        put(16'h00FF, 16'h2405);
        put(16'h0100, 16'h2505);
        put(16'h0101, 16'h9450);
        put(16'h0102, 16'hD060);
        put(16'h0200, 16'hE000);
        start_test(0, 1'b0);
        wait_halt("t2", 100);
        check("t2_r4", {16'd0, rf[4]}, 32'h0000);
        check("t2_r5", {16'd0, rf[5]}, 32'h0005);
        check("t2_jump_fetch", {16'd0, last_fetch}, 32'h0200);

        // T3: PUSH at SP=0 wraps, POP back, POP into SP itself.
        clear_all();
        rf_init[3] = 16'hBEEF;
        put(16'h0001, 16'h1234);
        put(16'h00FF, 16'h6030);
        put(16'h0100, 16'h7700);
        put(16'h0101, 16'h7200);
        put(16'h0102, 16'hE000);
        start_test(0, 1'b0);
        wait_halt("t3", 100);
        check("t3_m0", {16'd0, mem[0]}, 32'h0000BEEF);
        check("t3_r7", {16'd0, rf[7]}, 32'h0000BEEF);
        check("t3_sp_overwrite", {16'd0, rf[2]}, 32'h1234);

        // T4: LD with three wait states.
        clear_all();
        rf_init[9] = 16'h0300;
        put(16'h0300, 16'hCAFE);
        put(16'h00FF, 16'h4890);
        put(16'h0100, 16'hE000);
        start_test(3, 1'b0);
        wait_halt("t4", 100);
        check("t4_req_cycles", req300_cnt, 32'd4);
        check("t4_single_in_en", inen8_cnt, 32'd1);
        check("t4_r8", {16'd0, rf[8]}, 32'h0000CAFE);

        // T5: illegal opcode halts; stray acks ignored; reset recovers.
        clear_all();
        put(16'h00FF, 16'hF000);
        start_test(0, 1'b1);
        wait_halt("t5", 50);
        check("t5_flags", {30'd0, halted, illegal}, 32'd3);
        cnt = 0;
        repeat (20) begin @(negedge clk); #2; if (mem_req) cnt++; end
        check("t5_no_req", cnt, 32'd0);
        rst = 1'b1;
        #2 check("t5_rst_flags", {30'd0, halted, illegal}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #2 check("t5_refetch", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h00FF});

        // T6: reset in the middle of a pending ST.
        clear_all();
        rf_init[10] = 16'h0400;
        rf_init[11] = 16'h5555;
        put(16'h00FF, 16'h5AB0);
        put(16'h0100, 16'hE000);
        start_test(5, 1'b0);
        cnt = 0;
        while (!(mem_req && mem_we) && cnt < 50) begin @(negedge clk); #2; cnt++; end
        check("t6_store_seen", {31'd0, mem_req && mem_we}, 32'd1);
        @(negedge clk); #2;
        check_en = 1'b0;
        #1 rst = 1'b1;
        #1 check("t6_rst_quiet", {25'd0, mem_req, in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec}, 32'd0);
        start_test(5, 1'b0);
        #2 check("t6_refetch", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h00FF});
        wait_halt("t6", 100);
        check("t6_store_done", {16'd0, mem[16'h0400]}, 32'h5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
